// File: rtl/magnetron_pkg.sv
// magnetron_pkg: shared constants, types and helpers for the magnetron cook timer.
package magnetron_pkg;

  localparam int DIGIT_W = 4;

  // Number of one-second ticks the end-of-cook beep lasts.
  localparam logic [1:0] BEEP_TICKS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SET   = 2'd1,
    ST_COOK  = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  // mm:ss as four BCD digits, most significant first.
  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } cook_time_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return (d <= 4'd9);
  endfunction

  function automatic logic time_is_zero(input cook_time_t t);
    return (t == 16'd0);
  endfunction

endpackage

// File: rtl/magnetron_bcd_dec.sv
// magnetron_bcd_dec: combinational one-second decrement of a BCD mm:ss value.
// Seconds above 59 count down plainly; only 00 seconds borrow a minute and
// reload to 59. A value of 00:00 stays at 00:00.
module magnetron_bcd_dec
  import magnetron_pkg::*;
(
  input  logic [DIGIT_W-1:0] min_tens,
  input  logic [DIGIT_W-1:0] min_ones,
  input  logic [DIGIT_W-1:0] sec_tens,
  input  logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] dec_min_tens,
  output logic [DIGIT_W-1:0] dec_min_ones,
  output logic [DIGIT_W-1:0] dec_sec_tens,
  output logic [DIGIT_W-1:0] dec_sec_ones,
  output logic               zero
);

  // Borrow chain from the seconds ones digit up to the minute tens digit.
  always_comb begin
    dec_min_tens = min_tens;
    dec_min_ones = min_ones;
    dec_sec_tens = sec_tens;
    dec_sec_ones = sec_ones;
    if (sec_ones != 4'd0) begin
      dec_sec_ones = sec_ones - 4'd1;
    end else if (sec_tens != 4'd0) begin
      dec_sec_tens = sec_tens - 4'd1;
      dec_sec_ones = 4'd9;
    end else if (min_ones != 4'd0) begin
      dec_min_ones = min_ones - 4'd1;
      dec_sec_tens = 4'd5;
      dec_sec_ones = 4'd9;
    end else if (min_tens != 4'd0) begin
      dec_min_tens = min_tens - 4'd1;
      dec_min_ones = 4'd9;
      dec_sec_tens = 4'd5;
      dec_sec_ones = 4'd9;
    end else begin
      dec_sec_ones = 4'd0;
    end
    zero = (dec_min_tens == 4'd0) && (dec_min_ones == 4'd0) &&
           (dec_sec_tens == 4'd0) && (dec_sec_ones == 4'd0);
  end

endmodule

// File: rtl/magnetron_timer.sv
// magnetron_timer: cook-time entry, one-second prescaler, countdown FSM and
// magnetron enable. Optional end-of-cook beep is built only when the macro
// MAGNETRON_BEEP_EN is defined; otherwise beep is tied low.
module magnetron_timer
  import magnetron_pkg::*;
#(
  parameter int TICK_DIV = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s,
  input  logic               r,
  input  logic               clearn,
  input  logic               load,
  input  logic [DIGIT_W-1:0] digit_in,
  output logic               timer_done,
  output logic               mag_on,
  output logic [1:0]         state,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               beep
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  cook_time_t         time_r;
  cook_time_t         time_nxt_s;
  cook_time_t         dec_time_s;
  cook_time_t         shift_time_s;
  state_e             state_r;
  state_e             state_nxt_s;
  logic               mag_on_r;
  logic               mag_on_nxt_s;
  logic               timer_done_r;
  logic [PW-1:0]      presc_r;
  logic [PW-1:0]      presc_nxt_s;
  logic [PW-1:0]      presc_free_s;
  logic               presc_wrap_s;
  logic               dec_zero_s;
  logic               digit_ok_s;
  logic               start_s;
  logic               expiry_s;
  logic               beep_act_s;
  logic [DIGIT_W-1:0] dec_mt_s;
  logic [DIGIT_W-1:0] dec_mo_s;
  logic [DIGIT_W-1:0] dec_st_s;
  logic [DIGIT_W-1:0] dec_so_s;

  magnetron_bcd_dec u_dec (
    .min_tens     (time_r.min_tens),
    .min_ones     (time_r.min_ones),
    .sec_tens     (time_r.sec_tens),
    .sec_ones     (time_r.sec_ones),
    .dec_min_tens (dec_mt_s),
    .dec_min_ones (dec_mo_s),
    .dec_sec_tens (dec_st_s),
    .dec_sec_ones (dec_so_s),
    .zero         (dec_zero_s)
  );

  assign dec_time_s   = cook_time_t'({dec_mt_s, dec_mo_s, dec_st_s, dec_so_s});
  assign shift_time_s = cook_time_t'({time_r.min_ones, time_r.sec_tens,
                                      time_r.sec_ones, digit_in});
  assign digit_ok_s   = is_bcd(digit_in);
  assign presc_wrap_s = (presc_r == PRESC_MAX);
  // Free-running prescaler value, used while cooking and while a beep sounds.
  assign presc_free_s = presc_wrap_s ? PW'(0) : (presc_r + PW'(1));

  // Next-state, next-time and prescaler decisions in priority order:
  // clear, stop, tick decrement, start, digit load.
  always_comb begin
    time_nxt_s   = time_r;
    state_nxt_s  = state_r;
    mag_on_nxt_s = mag_on_r;
    presc_nxt_s  = presc_r;
    start_s      = 1'b0;
    expiry_s     = 1'b0;
    if (!clearn) begin
      time_nxt_s   = cook_time_t'(16'd0);
      state_nxt_s  = ST_IDLE;
      mag_on_nxt_s = 1'b0;
      presc_nxt_s  = PW'(0);
    end else begin
      case (state_r)
        ST_COOK: begin
          presc_nxt_s = presc_free_s;
          if (presc_wrap_s) begin
            time_nxt_s = dec_time_s;
            if (dec_zero_s) begin
              expiry_s     = 1'b1;
              state_nxt_s  = ST_IDLE;
              mag_on_nxt_s = 1'b0;
            end else if (r) begin
              state_nxt_s  = ST_PAUSE;
              mag_on_nxt_s = 1'b0;
            end else begin
              state_nxt_s  = ST_COOK;
              mag_on_nxt_s = 1'b1;
            end
          end else if (r) begin
            state_nxt_s  = ST_PAUSE;
            mag_on_nxt_s = 1'b0;
          end else begin
            state_nxt_s  = ST_COOK;
            mag_on_nxt_s = 1'b1;
          end
        end
        ST_SET, ST_PAUSE: begin
          if (s && !r) begin
            start_s      = 1'b1;
            state_nxt_s  = ST_COOK;
            mag_on_nxt_s = 1'b1;
            // A start that cuts a beep short begins a fresh second.
            presc_nxt_s  = beep_act_s ? PW'(0) : presc_r;
          end else begin
            mag_on_nxt_s = 1'b0;
            presc_nxt_s  = beep_act_s ? presc_free_s : presc_r;
            if (load && digit_ok_s) begin
              time_nxt_s  = shift_time_s;
              state_nxt_s = time_is_zero(shift_time_s) ? ST_IDLE : ST_SET;
              if (state_r == ST_PAUSE) begin
                presc_nxt_s = PW'(0);
              end else begin
                presc_nxt_s = beep_act_s ? presc_free_s : presc_r;
              end
            end else begin
              state_nxt_s = state_r;
            end
          end
        end
        default: begin
          mag_on_nxt_s = 1'b0;
          presc_nxt_s  = beep_act_s ? presc_free_s : presc_r;
          if (load && digit_ok_s) begin
            time_nxt_s  = shift_time_s;
            state_nxt_s = time_is_zero(shift_time_s) ? ST_IDLE : ST_SET;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
      endcase
    end
  end

  // Timer state registers; timer_done tracks whether the next time is 00:00.
  always_ff @(posedge clk) begin
    if (rst) begin
      time_r       <= cook_time_t'(16'd0);
      state_r      <= ST_IDLE;
      mag_on_r     <= 1'b0;
      timer_done_r <= 1'b1;
      presc_r      <= PW'(0);
    end else begin
      time_r       <= time_nxt_s;
      state_r      <= state_nxt_s;
      mag_on_r     <= mag_on_nxt_s;
      timer_done_r <= time_is_zero(time_nxt_s);
      presc_r      <= presc_nxt_s;
    end
  end

`ifdef MAGNETRON_BEEP_EN
  logic [1:0] beep_cnt_r;
  logic [1:0] beep_cnt_nxt_s;
  logic       beep_r;

  assign beep_act_s = (beep_cnt_r != 2'd0);

  // Beep tick counter: loaded on expiry, counts prescaler wraps down to zero.
  always_comb begin
    beep_cnt_nxt_s = beep_cnt_r;
    if (!clearn) begin
      beep_cnt_nxt_s = 2'd0;
    end else if (expiry_s) begin
      beep_cnt_nxt_s = BEEP_TICKS;
    end else if (start_s) begin
      beep_cnt_nxt_s = 2'd0;
    end else if (beep_act_s && presc_wrap_s) begin
      beep_cnt_nxt_s = beep_cnt_r - 2'd1;
    end else begin
      beep_cnt_nxt_s = beep_cnt_r;
    end
  end

  // Beep counter and registered beep output.
  always_ff @(posedge clk) begin
    if (rst) begin
      beep_cnt_r <= 2'd0;
      beep_r     <= 1'b0;
    end else begin
      beep_cnt_r <= beep_cnt_nxt_s;
      beep_r     <= (beep_cnt_nxt_s != 2'd0);
    end
  end

  assign beep = beep_r;
`else
  logic unused_beep_s;

  assign beep_act_s    = 1'b0;
  assign unused_beep_s = start_s ^ expiry_s;
  assign beep          = 1'b0;
`endif

  assign timer_done = timer_done_r;
  assign mag_on     = mag_on_r;
  assign state      = state_r;
  assign min_tens   = time_r.min_tens;
  assign min_ones   = time_r.min_ones;
  assign sec_tens   = time_r.sec_tens;
  assign sec_ones   = time_r.sec_ones;

endmodule

// File: tb/tb_magnetron_timer.sv
// tb_magnetron_timer: directed test-plan scenarios followed by randomized
// traffic, every cycle compared against a minutes/seconds reference model.
module tb_magnetron_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       s;
  logic       r;
  logic       clearn;
  logic       load;
  logic [3:0] digit_in;
  logic       timer_done;
  logic       mag_on;
  logic [1:0] state;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       beep;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: time as integer minutes/seconds, mode 0..3, phase within second.
  int m_min, m_sec, m_mode, m_phase, m_beep;

  always #5 clk = ~clk;

  magnetron_timer #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (s),
    .r          (r),
    .clearn     (clearn),
    .load       (load),
    .digit_in   (digit_in),
    .timer_done (timer_done),
    .mag_on     (mag_on),
    .state      (state),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .beep       (beep)
  );

  task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic model_step();
    int v;
    if (rst || !clearn) begin
      m_min = 0; m_sec = 0; m_mode = 0; m_phase = 0; m_beep = 0;
    end else begin
      if (m_mode != 2 && m_beep > 0) m_beep--;
      if (m_mode == 2) begin
        m_phase++;
        if (m_phase == TD) begin
          m_phase = 0;
          if (m_sec > 0) m_sec--;
          else begin m_min--; m_sec = 59; end
          if (m_min == 0 && m_sec == 0) begin
            m_mode = 0;
`ifdef MAGNETRON_BEEP_EN
            m_beep = 3 * TD;
`endif
          end else if (r) m_mode = 3;
        end else if (r) m_mode = 3;
      end else if ((m_mode == 1 || m_mode == 3) && s && !r) begin
        if (m_beep > 0) m_phase = 0;
        m_beep = 0;
        m_mode = 2;
      end else if (load && int'(digit_in) <= 9) begin
        v = ((m_min * 100 + m_sec) * 10 + int'(digit_in)) % 10000;
        m_min = v / 100;
        m_sec = v % 100;
        if (m_mode == 3) m_phase = 0;
        m_mode = (v == 0) ? 0 : 1;
      end
    end
  endtask

  task automatic check_all();
    chk("min_tens",   8'(min_tens),   8'(m_min / 10));
    chk("min_ones",   8'(min_ones),   8'(m_min % 10));
    chk("sec_tens",   8'(sec_tens),   8'(m_sec / 10));
    chk("sec_ones",   8'(sec_ones),   8'(m_sec % 10));
    chk("timer_done", 8'(timer_done), 8'(m_min == 0 && m_sec == 0));
    chk("mag_on",     8'(mag_on),     8'(m_mode == 2));
    chk("state",      8'(state),      8'(m_mode));
    chk("beep",       8'(beep),       8'(m_beep > 0));
  endtask

  // One clock: model follows the sampled inputs, outputs checked 1 unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic key(input logic [3:0] d);
    load = 1'b1; digit_in = d;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_clear();
    clearn = 1'b0;
    cyc();
    clearn = 1'b1;
  endtask

  int cnt;

  initial begin
    rst = 1'b1; s = 1'b0; r = 1'b0; clearn = 1'b1; load = 1'b0; digit_in = 4'd0;
    m_min = 0; m_sec = 0; m_mode = 0; m_phase = 0; m_beep = 0;
    cyc(); cyc();
    chk("rst_digits", 8'({min_tens, min_ones} | {sec_tens, sec_ones}), 8'd0);
    chk("rst_done", 8'(timer_done), 8'd1);
    chk("rst_mag", 8'(mag_on), 8'd0);
    chk("rst_state", 8'(state), 8'd0);
    rst = 1'b0;
    cyc();

    // Entry and full cook of 00:12.
    key(4'd0); key(4'd0); key(4'd1); key(4'd2);
    chk("entry_state", 8'(state), 8'd1);
    chk("entry_done", 8'(timer_done), 8'd0);
    s = 1'b1; cyc(); s = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200 && mag_on; i++) begin
      cnt++;
      cyc();
    end
    chk("cook_len", 8'(cnt), 8'd48);
    chk("cook_done", 8'(timer_done), 8'd1);
    chk("cook_state", 8'(state), 8'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (beep) cnt++;
      cyc();
    end
`ifdef MAGNETRON_BEEP_EN
    chk("beep_len", 8'(cnt), 8'd12);
`else
    chk("beep_len", 8'(cnt), 8'd0);
`endif

    // Minute borrow: 01:00 -> 00:59 after one second.
    key(4'd1); key(4'd0); key(4'd0);
    s = 1'b1; cyc(); s = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("borrow_min", 8'({min_tens, min_ones}), 8'd0);
    chk("borrow_sec", 8'({sec_tens, sec_ones}), 8'h59);
    do_clear();

    // Pause two cycles into a second, then resume.
    key(4'd0); key(4'd5);
    s = 1'b1; cyc(); s = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    cyc();
    r = 1'b1; cyc(); r = 1'b0;
    chk("pause_mag", 8'(mag_on), 8'd0);
    chk("pause_state", 8'(state), 8'd3);
    cyc(); cyc(); cyc(); cyc(); cyc();
    chk("pause_frozen", 8'(sec_ones), 8'd4);
    s = 1'b1; cyc(); s = 1'b0;
    cyc();
    chk("resume_hold", 8'(sec_ones), 8'd4);
    cyc();
    chk("resume_tick", 8'(sec_ones), 8'd3);
    for (int i = 0; i < 100 && !timer_done; i++) cyc();
    chk("pause_end", 8'(timer_done), 8'd1);

    // Clear mid-cook at 00:07.
    key(4'd0); key(4'd9);
    s = 1'b1; cyc(); s = 1'b0;
    for (int i = 0; i < 40 && sec_ones != 4'd7; i++) cyc();
    chk("clr_reach7", 8'(sec_ones), 8'd7);
    do_clear();
    chk("clr_digits", 8'({min_tens, min_ones} | {sec_tens, sec_ones}), 8'd0);
    chk("clr_done", 8'(timer_done), 8'd1);
    chk("clr_mag", 8'(mag_on), 8'd0);
    chk("clr_state", 8'(state), 8'd0);
    s = 1'b1; cyc(); s = 1'b0;
    chk("clr_nostart", 8'(mag_on), 8'd0);

    // Conflicts: s with r in SET, load during COOK, out-of-range digit.
    key(4'd3);
    key(4'd12);
    chk("bad_digit", 8'(sec_ones), 8'd3);
    s = 1'b1; r = 1'b1; cyc(); s = 1'b0; r = 1'b0;
    chk("sr_mag", 8'(mag_on), 8'd0);
    s = 1'b1; cyc(); s = 1'b0;
    key(4'd5);
    chk("cook_load_ign", 8'(sec_ones), 8'd3);
    chk("cook_load_min", 8'({min_tens, min_ones, sec_tens}), 8'd0);
    do_clear();

    // Randomized sessions.
    for (int it = 0; it < 40; it++) begin
      do_clear();
      key(4'($urandom_range(0, 3)));
      key(4'($urandom_range(0, 9)));
      s = 1'b1; cyc(); s = 1'b0;
      for (int k = 0; k < 150; k++) begin
        r        = ($urandom_range(0, 29) == 0);
        s        = ($urandom_range(0, 9) == 0);
        load     = ($urandom_range(0, 15) == 0);
        digit_in = 4'($urandom_range(0, 11));
        clearn   = ($urandom_range(0, 199) != 0);
        rst      = ($urandom_range(0, 499) == 0);
        cyc();
      end
      r = 1'b0; s = 1'b0; load = 1'b0; clearn = 1'b1; rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
